// File: rtl/pd_sensor_scheduler_if.sv
// rtl/pd_sensor_scheduler_if.sv - APB port bundle between the PD sensor scheduler and the sensor slave
interface pd_sensor_scheduler_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [3:0]  PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/pd_sensor_scheduler.sv
// rtl/pd_sensor_scheduler.sv - autonomous APB sequencer for the PD sensor with a result FIFO
module pd_sensor_scheduler #(
    parameter int          FIFO_DEPTH     = 4,
    parameter int          TIMEOUT_CYCLES = 4096,
    parameter logic [3:0]  CTRL_ADDR      = 4'h0,
    parameter logic [3:0]  DATA_ADDR      = 4'h4,
    parameter logic [31:0] START_VAL      = 32'h0000_0001
) (
    input  logic                        HCLK,
    input  logic                        HRESETn,
    input  logic                        enable,
    input  logic [23:0]                 period_cycles,
    pd_sensor_scheduler_if.master       apb,
    input  logic                        irq_pd_rdy,
    output logic                        sample_valid,
    output logic [31:0]                 sample_data,
    input  logic                        sample_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        err_timeout,
    output logic                        err_slverr,
    output logic                        err_overflow,
    input  logic                        err_clear
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, WR_SETUP, WR_ACCESS, WAIT_IRQ, RD_SETUP, RD_ACCESS, WAIT_PERIOD
    } state_t;

    state_t        state;
    logic [23:0]   pcnt;
    logic [23:0]   period_load;
    logic [TW-1:0] tcnt;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic period_due, reload, timeout_hit;
    logic push_req, push, pop, full;
    logic ev_timeout, ev_slverr, ev_overflow;

    assign period_load = (period_cycles == 24'd0) ? 24'd0 : period_cycles - 24'd1;
    assign period_due  = (pcnt == 24'd0);
    assign reload      = enable && ((state == IDLE) || (state == WAIT_PERIOD && period_due));
    assign timeout_hit = (tcnt == TW'(TIMEOUT_CYCLES - 1));

    assign sample_valid = (count != '0);
    assign sample_data  = sample_valid ? mem[rd_ptr] : 32'd0;
    assign fifo_level   = count;
    assign full         = (count == (AW+1)'(FIFO_DEPTH));
    assign pop          = sample_valid && sample_ready;
    assign push_req     = (state == RD_ACCESS) && apb.PREADY && !apb.PSLVERR;
    // A pop in the same cycle frees the slot, so a full FIFO only drops when nothing leaves.
    assign push         = push_req && !(full && !pop);

    assign ev_overflow = push_req && full && !pop;
    assign ev_slverr   = ((state == WR_ACCESS) || (state == RD_ACCESS)) && apb.PREADY && apb.PSLVERR;
    assign ev_timeout  = (state == WAIT_IRQ) && enable && !irq_pd_rdy && timeout_hit;

    assign apb.PPROT = 3'b000;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            pcnt <= 24'd0;
        end else if (reload) begin
            pcnt <= period_load;
        end else if (state != IDLE && !period_due) begin
            pcnt <= pcnt - 24'd1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state       <= IDLE;
            tcnt        <= '0;
            apb.PSEL    <= 1'b0;
            apb.PENABLE <= 1'b0;
            apb.PWRITE  <= 1'b0;
            apb.PADDR   <= 4'h0;
            apb.PWDATA  <= 32'd0;
            apb.PSTRB   <= 4'h0;
        end else begin
            case (state)
                IDLE, WAIT_PERIOD: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (reload) begin
                        state       <= WR_SETUP;
                        apb.PSEL    <= 1'b1;
                        apb.PWRITE  <= 1'b1;
                        apb.PADDR   <= CTRL_ADDR;
                        apb.PWDATA  <= START_VAL;
                        apb.PSTRB   <= 4'hF;
                    end
                end
                WR_SETUP: begin
                    state       <= WR_ACCESS;
                    apb.PENABLE <= 1'b1;
                end
                WR_ACCESS: begin
                    if (apb.PREADY) begin
                        apb.PSEL    <= 1'b0;
                        apb.PENABLE <= 1'b0;
                        apb.PWRITE  <= 1'b0;
                        apb.PADDR   <= 4'h0;
                        apb.PWDATA  <= 32'd0;
                        apb.PSTRB   <= 4'h0;
                        if (!enable) begin
                            state <= IDLE;
                        end else if (apb.PSLVERR) begin
                            state <= WAIT_PERIOD;
                        end else begin
                            state <= WAIT_IRQ;
                            tcnt  <= '0;
                        end
                    end
                end
                WAIT_IRQ: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (irq_pd_rdy) begin
                        state      <= RD_SETUP;
                        apb.PSEL   <= 1'b1;
                        apb.PWRITE <= 1'b0;
                        apb.PADDR  <= DATA_ADDR;
                        apb.PWDATA <= 32'd0;
                        apb.PSTRB  <= 4'h0;
                    end else if (timeout_hit) begin
                        state <= WAIT_PERIOD;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                RD_SETUP: begin
                    state       <= RD_ACCESS;
                    apb.PENABLE <= 1'b1;
                end
                RD_ACCESS: begin
                    if (apb.PREADY) begin
                        apb.PSEL    <= 1'b0;
                        apb.PENABLE <= 1'b0;
                        apb.PADDR   <= 4'h0;
                        state       <= enable ? WAIT_PERIOD : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            err_timeout  <= 1'b0;
            err_slverr   <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            err_timeout  <= (err_timeout  && !err_clear) || ev_timeout;
            err_slverr   <= (err_slverr   && !err_clear) || ev_slverr;
            err_overflow <= (err_overflow && !err_clear) || ev_overflow;
        end
    end

    always_ff @(posedge HCLK) begin
        if (push) begin
            mem[wr_ptr] <= apb.PRDATA;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
